// File: rtl/axis_fifo_serializer.sv
// AXI-stream style FIFO followed by a wide-to-narrow serializer.
// Wide words are buffered in a DEPTH-entry FIFO, pass through a registered
// read stage, and are emitted one DATA_WIDTH slice at a time, LSB slice first.
module axis_fifo_serializer #(
    parameter int DATA_NB      = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_NB*DATA_WIDTH-1:0] up_data,
    input  logic                          up_valid,
    output logic                          up_ready,
    output logic [DATA_WIDTH-1:0]         down_data,
    output logic                          down_valid,
    input  logic                          down_ready,
    output logic [ADDR_WIDTH:0]           count,
    output logic                          empty,
    output logic                          full,
    output logic                          full_a
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int WIDE  = DATA_NB * DATA_WIDTH;
    localparam int IDX_W = (DATA_NB > 1) ? $clog2(DATA_NB) : 1;
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(DATA_NB - 1);
    localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH + 1)'(DEPTH - AFULL_MARGIN);

    logic [WIDE-1:0]       mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic                  stage_valid;
    logic [WIDE-1:0]       stage_data;

    logic                  ser_busy;
    logic [WIDE-1:0]       ser_data;
    logic [IDX_W-1:0]      idx;

    logic                  push;
    logic                  pop;
    logic                  fifo_pop;
    logic                  ser_take;
    logic                  down_fire;

    // Status flags all come from the registered word count
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign full_a   = (count >= AFULL_CNT);
    assign up_ready = ~full;

    // The held word is shifted down as slices leave, so slice 0 is always on top
    assign down_valid = ser_busy;
    assign down_data  = ser_data[DATA_WIDTH-1:0];

    assign push      = up_valid & ~full;
    assign down_fire = ser_busy & down_ready;
    assign ser_take  = ~ser_busy | (down_fire & (idx == IDX_LAST));
    assign pop       = ~stage_valid | ser_take;
    assign fifo_pop  = pop & ~empty;

    // FIFO storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= up_data;
        end
    end

    // Pointers, occupancy, read stage and serializer state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            ser_busy    <= 1'b0;
            ser_data    <= '0;
            idx         <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (pop) begin
                stage_valid <= ~empty;
                if (!empty) begin
                    stage_data <= mem[rd_ptr];
                    rd_ptr     <= rd_ptr + 1'b1;
                end
            end

            case ({push, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (ser_take) begin
                ser_busy <= stage_valid;
                idx      <= '0;
                if (stage_valid) begin
                    ser_data <= stage_data;
                end
            end else if (down_fire) begin
                ser_data <= ser_data >> DATA_WIDTH;
                idx      <= idx + IDX_ONE;
            end
        end
    end

endmodule

// File: tb/tb_axis_fifo_serializer.sv
// Self-checking bench for axis_fifo_serializer (2 x 8-bit slices, depth 4).
// A queue of expected narrow words is built from every accepted push and
// compared against the words actually handed over downstream.
module tb_axis_fifo_serializer;

    logic        clk;
    logic        rst;
    logic [15:0] up_data;
    logic        up_valid;
    logic        up_ready;
    logic [7:0]  down_data;
    logic        down_valid;
    logic        down_ready;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        full_a;

    int checks;
    int passes;
    int cyc;
    int n_acc;
    int stall_err;
    logic       have_stall;
    logic [7:0] stall_data;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_t[$];

    axis_fifo_serializer #(
        .DATA_NB(2), .DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_MARGIN(1)
    ) dut (
        .clk(clk), .rst(rst),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready),
        .count(count), .empty(empty), .full(full), .full_a(full_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive at negedge, record handshakes, advance to the next posedge
    task automatic cycle(input logic uv, input logic [15:0] ud, input logic dr);
        @(negedge clk);
        up_valid   = uv;
        up_data    = ud;
        down_ready = dr;
        #1;
        if (uv && up_ready) begin
            exp_q.push_back(ud[7:0]);
            exp_q.push_back(ud[15:8]);
            n_acc++;
        end
        if (have_stall && (down_valid !== 1'b1 || down_data !== stall_data))
            stall_err++;
        if (down_valid && dr) begin
            got_q.push_back(down_data);
            got_t.push_back(cyc);
        end
        have_stall = down_valid && !dr;
        stall_data = down_data;
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        up_valid   = 1'b0;
        down_ready = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.delete();
        got_q.delete();
        got_t.delete();
        n_acc      = 0;
        stall_err  = 0;
        have_stall = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (down_valid !== 1'b0) $display("[TB] FAIL reset_down_valid got %b want 0", down_valid); else passes++;
        checks++; if (down_data !== 8'h00) $display("[TB] FAIL reset_down_data got %h want 00", down_data); else passes++;
        checks++; if (count !== 3'd0) $display("[TB] FAIL reset_count got %0d want 0", count); else passes++;
        checks++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty got %b want 1", empty); else passes++;
        checks++; if (full !== 1'b0) $display("[TB] FAIL reset_full got %b want 0", full); else passes++;
        checks++; if (full_a !== 1'b0) $display("[TB] FAIL reset_full_a got %b want 0", full_a); else passes++;
        checks++; if (up_ready !== 1'b1) $display("[TB] FAIL reset_up_ready got %b want 1", up_ready); else passes++;
    endtask

    task automatic test_single_word();
        logic       dv [5];
        logic [7:0] dd [5];
        logic [2:0] c0;
        logic       e4;
        do_reset();
        cycle(1'b1, 16'hBBAA, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            up_valid   = 1'b0;
            down_ready = 1'b1;
            #1;
            dv[k] = down_valid;
            dd[k] = down_data;
            if (k == 0) c0 = count;
            if (k == 4) e4 = empty;
            @(posedge clk);
            cyc++;
        end
        checks++; if (c0 !== 3'd1) $display("[TB] FAIL single_count got %0d want 1", c0); else passes++;
        checks++; if (dv[0] !== 1'b0 || dv[1] !== 1'b0) $display("[TB] FAIL single_early_valid got %b%b want 00", dv[0], dv[1]); else passes++;
        checks++; if (dv[2] !== 1'b1 || dd[2] !== 8'hAA) $display("[TB] FAIL single_first got v=%b d=%h want v=1 d=aa", dv[2], dd[2]); else passes++;
        checks++; if (dv[3] !== 1'b1 || dd[3] !== 8'hBB) $display("[TB] FAIL single_second got v=%b d=%h want v=1 d=bb", dv[3], dd[3]); else passes++;
        checks++; if (dv[4] !== 1'b0 || e4 !== 1'b1) $display("[TB] FAIL single_idle got v=%b empty=%b want v=0 empty=1", dv[4], e4); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] want [6];
        want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_reset();
        cycle(1'b1, 16'h2211, 1'b1);
        cycle(1'b1, 16'h4433, 1'b1);
        cycle(1'b1, 16'h6655, 1'b1);
        for (int k = 0; k < 10; k++) cycle(1'b0, 16'h0000, 1'b1);
        checks++;
        if (got_q.size() != 6) $display("[TB] FAIL b2b_len got %0d want 6", got_q.size());
        else passes++;
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== want[i]) $display("[TB] FAIL b2b_data[%0d] got %h want %h", i, got_q[i], want[i]);
            else passes++;
        end
        for (int i = 1; i < got_t.size(); i++) begin
            checks++;
            if (got_t[i] != got_t[i-1] + 1) $display("[TB] FAIL b2b_gap[%0d] got %0d cycles want 1", i, got_t[i] - got_t[i-1]);
            else passes++;
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 7; k++) cycle(1'b1, 16'(16'h1010 * (k + 1) + 16'h0102), 1'b0);
        cycle(1'b1, 16'hEEEE, 1'b0);
        cycle(1'b1, 16'hFFFF, 1'b0);
        @(negedge clk);
        #1;
        checks++; if (n_acc != 6) $display("[TB] FAIL full_accepted got %0d want 6", n_acc); else passes++;
        checks++; if (count !== 3'd4) $display("[TB] FAIL full_count got %0d want 4", count); else passes++;
        checks++; if (full !== 1'b1 || full_a !== 1'b1 || up_ready !== 1'b0)
            $display("[TB] FAIL full_flags got full=%b full_a=%b up_ready=%b want 1 1 0", full, full_a, up_ready);
        else passes++;
        checks++; if (down_valid !== 1'b1 || got_q.size() != 0) $display("[TB] FAIL full_stalled got v=%b n=%0d want v=1 n=0", down_valid, got_q.size()); else passes++;
        for (int k = 0; k < 25; k++) cycle(1'b0, 16'h0000, 1'b1);
        checks++;
        if (got_q.size() != exp_q.size()) $display("[TB] FAIL full_drain_len got %0d want %0d", got_q.size(), exp_q.size());
        else passes++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("[TB] FAIL full_drain[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            else passes++;
        end
        checks++; if (empty !== 1'b1 || full_a !== 1'b0) $display("[TB] FAIL full_after_drain got empty=%b full_a=%b want 1 0", empty, full_a); else passes++;
    endtask

    task automatic test_random_stall();
        do_reset();
        for (int k = 0; k < 300; k++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0 ? 1 : 0));
        for (int k = 0; k < 40; k++) cycle(1'b0, 16'h0000, 1'b1);
        checks++; if (stall_err != 0) $display("[TB] FAIL rand_stall_stable got %0d changes want 0", stall_err); else passes++;
        checks++;
        if (got_q.size() != exp_q.size()) $display("[TB] FAIL rand_len got %0d want %0d", got_q.size(), exp_q.size());
        else passes++;
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                if (got_q[i] !== exp_q[i]) bad++;
            checks++;
            if (bad != 0 || exp_q.size() == 0) $display("[TB] FAIL rand_order got %0d wrong of %0d want 0 wrong", bad, exp_q.size());
            else passes++;
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        cycle(1'b1, 16'hBBAA, 1'b1);
        cycle(1'b1, 16'h2211, 1'b1);
        cycle(1'b1, 16'h4433, 1'b1);
        for (int k = 0; k < 10 && got_q.size() == 0; k++) cycle(1'b0, 16'h0000, 1'b1);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hAA) $display("[TB] FAIL mid_pre_reset got n=%0d want one aa", got_q.size());
        else passes++;
        do_reset();
        checks++; if (down_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1)
            $display("[TB] FAIL mid_after_reset got v=%b count=%0d empty=%b want 0 0 1", down_valid, count, empty);
        else passes++;
        cycle(1'b1, 16'hDDCC, 1'b1);
        for (int k = 0; k < 8; k++) cycle(1'b0, 16'h0000, 1'b1);
        checks++;
        if (got_q.size() != 2) $display("[TB] FAIL mid_post_len got %0d want 2", got_q.size());
        else passes++;
        checks++;
        if (got_q.size() < 2 || got_q[0] !== 8'hCC || got_q[1] !== 8'hDD) $display("[TB] FAIL mid_post_data got n=%0d want cc dd", got_q.size());
        else passes++;
    endtask

    initial begin
        checks = 0; passes = 0; cyc = 0;
        rst = 1'b1; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;
        have_stall = 1'b0; stall_data = '0; n_acc = 0; stall_err = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_full();
        test_random_stall();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axis_fifo_serializer.md
AXIS_FIFO_SERIALIZER -- requirements
Module: axis_fifo_serializer

Interface
REQ-001 Parameter DATA_NB, default 2: number of narrow words per wide input word (>=1).
REQ-002 Parameter DATA_WIDTH, default 32: narrow output word width in bits.
REQ-003 Parameter ADDR_WIDTH, default 9: FIFO address width; depth DEPTH = 2^ADDR_WIDTH wide words.
REQ-004 Parameter AFULL_MARGIN, default 2: almost-full threshold distance from DEPTH.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 up_data  input  DATA_NB*DATA_WIDTH  wide word to buffer.
REQ-008 up_valid  input  1  up_data valid.
REQ-009 up_ready  output  1  FIFO can accept a word.
REQ-010 down_data  output  DATA_WIDTH  current narrow word.
REQ-011 down_valid  output  1  down_data valid.
REQ-012 down_ready  input  1  consumer accepts down_data.
REQ-013 count  output  ADDR_WIDTH+1  wide words stored in FIFO memory.
REQ-014 empty  output  1  count == 0.
REQ-015 full  output  1  count == DEPTH.
REQ-016 full_a  output  1  count >= DEPTH-AFULL_MARGIN.

Function
REQ-017 Push: up_valid & up_ready at a rising edge writes up_data at the write pointer; pointer wraps modulo DEPTH.
REQ-018 up_ready SHALL equal ~full (combinational from registered count); no write ever occurs when full.
REQ-019 FIFO read is registered: an internal pop at an edge presents the head word on the read register after that edge; a pop while empty is ignored and leaves the stage invalid.
REQ-020 Internal stage: stage_valid register; pop = ~stage_valid | ser_take; on pop, stage_valid <= ~empty.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-022 Serializer holds one wide word and slice index idx (0..DATA_NB-1); ser_take (loads stage word) when serializer idle, or when down_valid & down_ready & idx == DATA_NB-1.
REQ-023 down_data = slice idx of held word, slice k = bits [k*DATA_WIDTH +: DATA_WIDTH]; least-significant slice emitted first.
REQ-024 down_valid high while a held word has unsent slices; each down_valid & down_ready edge advances idx; after slice DATA_NB-1 it loads the next stage word (idx=0) if stage_valid, else goes idle (down_valid=0).
REQ-025 down_data/down_valid stable while down_valid & ~down_ready.
REQ-026 Latency: word pushed into empty block at edge E0 -> down_valid first high after edge E0+2 (down_ready held high).
REQ-027 Throughput: with down_ready held high and FIFO non-empty, one narrow word per cycle, no bubbles between wide words.
REQ-028 count increments on push-only, decrements on pop of non-empty FIFO-only; empty/full/full_a derived from count.

Reset
REQ-029 rst at an edge: pointers and count = 0, empty=1, full=0, full_a=0, up_ready=1, stage_valid=0, idx=0, serializer idle, down_valid=0, down_data=0; FIFO memory contents not cleared.
REQ-030 rst mid-operation discards all buffered and partially serialized words; no slice of a pre-reset word appears after reset.

Verification (DATA_NB=2, DATA_WIDTH=8, ADDR_WIDTH=2, AFULL_MARGIN=1)
REQ-031 Push 16'hBBAA once, down_ready=1 -> down_valid after E0+2; down_data 8'hAA then 8'hBB on consecutive cycles; then down_valid=0, empty=1.
REQ-032 Push 16'h2211,16'h4433,16'h6655 back-to-back, down_ready=1 -> 11,22,33,44,55,66 on six consecutive cycles.
REQ-033 down_ready=0, push 7 words -> after ~6 pushes up_ready=0, full=1, count=4, full_a=1; further up_valid ignored; release down_ready -> all accepted words emitted in order, none lost or duplicated.
REQ-034 Random down_ready toggling during stream -> down_data held stable while stalled; output sequence equals input slices in order.
REQ-035 Assert rst after AA emitted but before BB -> down_valid=0, count=0, empty=1 next cycle; BB never emitted; new push 16'hDDCC yields CC, DD.
